// File: rtl/uart_tx_buffered_serializer.sv
// Double-buffered parallel-to-serial engine for the UART TX path; optional parity via UART_TX_SER_PARITY_EN.
// Latency: accept at N, transfer to shift register at N+1, first bit on the first EN at or after N+2.
// Backpressure: DATA_READY is low while the holding register is full; back-to-back words stream with no gap ticks.
module uart_tx_buffered_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    output logic                  DATA_READY,
    input  logic                  EN,
    input  logic                  MSB_FIRST,
    input  logic                  PAR_TYPE,
    output logic                  S_DATA,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  PAR_BIT
);

    localparam int CNT_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(DATA_WIDTH - 1);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  msb_q, msb_d;
    logic                  s_data_q, s_data_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;

    logic                  accept;
    logic                  tick;
    logic                  last_tick;
    logic                  transfer;
    logic [CNT_WIDTH-1:0]  bit_idx;

    // Handshake, shift tick and hold-to-shift transfer decisions plus next-state values.
    always_comb begin
        accept      = DATA_VALID & ~hold_full_q;
        tick        = (state_q == S_SHIFT) & EN;
        last_tick   = tick & (count_q == LAST_IDX);
        // The hold refills the shift register either from idle or on the final bit of
        // the current word, which is what gives zero-gap streaming.
        transfer    = hold_full_q & ((state_q == S_IDLE) | last_tick);
        bit_idx     = msb_q ? (LAST_IDX - count_q) : count_q;

        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        count_d     = count_q;
        msb_d       = msb_q;
        s_data_d    = s_data_q;
        done_d      = last_tick;

        // Accept needs an empty hold and transfer needs a full one, so they never collide.
        if (accept) begin
            hold_d      = P_DATA;
            hold_full_d = 1'b1;
        end else if (transfer) begin
            hold_full_d = 1'b0;
        end

        if (tick) begin
            s_data_d = shift_q[bit_idx];
            count_d  = last_tick ? '0 : count_q + 1'b1;
        end

        if (transfer) begin
            shift_d = hold_q;
            count_d = '0;
            msb_d   = MSB_FIRST;
            state_d = S_SHIFT;
        end else if (last_tick) begin
            state_d = S_IDLE;
        end

        // BUSY stays up through the DONE cycle and drops one cycle later when idle.
        busy_d = (state_d == S_SHIFT) | last_tick;
    end

    // State and datapath registers; reset discards any frame in progress.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            count_q     <= '0;
            msb_q       <= 1'b0;
            s_data_q    <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            count_q     <= count_d;
            msb_q       <= msb_d;
            s_data_q    <= s_data_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

`ifdef UART_TX_SER_PARITY_EN
    logic par_bit_q, par_bit_d;

    // Parity of the incoming word is captured at transfer and held for the whole word.
    always_comb begin
        par_bit_d = par_bit_q;
        if (transfer) begin
            par_bit_d = PAR_TYPE ? ~^hold_q : ^hold_q;
        end
    end

    // Parity register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_bit_q <= 1'b0;
        end else begin
            par_bit_q <= par_bit_d;
        end
    end

    assign PAR_BIT = par_bit_q;
`else
    logic unused_par_type;
    assign unused_par_type = PAR_TYPE;
    assign PAR_BIT         = 1'b0;
`endif

    assign DATA_READY = ~hold_full_q;
    assign S_DATA     = s_data_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;

endmodule

// File: tb/tb_uart_tx_buffered_serializer.sv
// Directed bench for uart_tx_buffered_serializer with a queue-based reference model.
// Inputs change 2 time units after each rising edge; outputs are compared on the falling edge.
// The model tracks the pending word, the bit stream still to be sent, and the DONE/BUSY/parity flags.
module tb_uart_tx_buffered_serializer;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic [W-1:0] P_DATA = '0;
    logic         DATA_VALID = 1'b0;
    logic         DATA_READY;
    logic         EN = 1'b0;
    logic         MSB_FIRST = 1'b0;
    logic         PAR_TYPE = 1'b0;
    logic         S_DATA;
    logic         BUSY;
    logic         DONE;
    logic         PAR_BIT;

    int total = 0;
    int bad   = 0;

    uart_tx_buffered_serializer #(.DATA_WIDTH(W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .P_DATA    (P_DATA),
        .DATA_VALID(DATA_VALID),
        .DATA_READY(DATA_READY),
        .EN        (EN),
        .MSB_FIRST (MSB_FIRST),
        .PAR_TYPE  (PAR_TYPE),
        .S_DATA    (S_DATA),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .PAR_BIT   (PAR_BIT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a pending-word queue and a queue of bits still to send.
    logic [W-1:0] m_hold[$];
    bit           m_bits[$];
    logic         m_active = 1'b0;
    logic         m_sdata  = 1'b0;
    logic         m_done   = 1'b0;
    logic         m_busy   = 1'b0;
    logic         m_par    = 1'b0;

    always @(posedge CLK or negedge RST) begin
        logic         acc;
        logic [W-1:0] w;
        bit           fin;
        if (!RST) begin
            m_hold.delete();
            m_bits.delete();
            m_active = 1'b0;
            m_sdata  = 1'b0;
            m_done   = 1'b0;
            m_busy   = 1'b0;
            m_par    = 1'b0;
        end else begin
            acc    = DATA_VALID && (m_hold.size() == 0);
            fin    = 1'b0;
            m_done = 1'b0;
            if (m_active && EN) begin
                m_sdata = m_bits.pop_front();
                if (m_bits.size() == 0) begin
                    fin      = 1'b1;
                    m_done   = 1'b1;
                    m_active = 1'b0;
                end
            end
            if (!m_active && (m_hold.size() != 0)) begin
                w = m_hold.pop_front();
                for (int i = 0; i < W; i++) begin
                    m_bits.push_back(MSB_FIRST ? w[W-1-i] : w[i]);
                end
                m_active = 1'b1;
`ifdef UART_TX_SER_PARITY_EN
                m_par = PAR_TYPE ? ~^w : ^w;
`else
                m_par = 1'b0;
`endif
            end
            if (acc) begin
                m_hold.push_back(P_DATA);
            end
            m_busy = m_active || fin;
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge CLK) begin
        chk("s_data", 32'(S_DATA), 32'(m_sdata));
        chk("done", 32'(DONE), 32'(m_done));
        chk("busy", 32'(BUSY), 32'(m_busy));
        chk("data_ready", 32'(DATA_READY), 32'(m_hold.size() == 0));
        chk("par_bit", 32'(PAR_BIT), 32'(m_par));
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic send(input logic [W-1:0] w);
        P_DATA     = w;
        DATA_VALID = 1'b1;
        tick();
        DATA_VALID = 1'b0;
    endtask

    initial begin
        logic [W-1:0] got;
        logic [15:0]  got16;
        int           done_idx[$];
        int           dn;
        int           ens;
        int           illegal;
        int           done_at;
        bit           seen;
        logic         prev;
        logic         cur_en;
        logic         exp_par;

        // Reset state
        repeat (2) @(posedge CLK);
        #2;
        chk("rst_s_data", 32'(S_DATA), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_ready", 32'(DATA_READY), 32'd1);
        chk("rst_par", 32'(PAR_BIT), 32'd0);
        RST = 1'b1;
        tick();

        // 8'hC1 LSB-first, EN continuous
        EN = 1'b1;
        MSB_FIRST = 1'b0;
        send(8'hC1);
        chk("t2_ready_after_accept", 32'(DATA_READY), 32'd0);
        tick();
        chk("t2_busy_after_transfer", 32'(BUSY), 32'd1);
        got = '0;
        dn = 0;
        for (int i = 0; i < W; i++) begin
            tick();
            got[i] = S_DATA;
            if (i < W - 1 && DONE) dn++;
        end
        chk("t2_done_on_8th", 32'(DONE), 32'd1);
        chk("t2_no_early_done", 32'(dn), 32'd0);
        chk("t2_bits", 32'(got), 32'h0000_00C1);
        tick();
        chk("t2_busy_fall", 32'(BUSY), 32'd0);
        chk("t2_done_fall", 32'(DONE), 32'd0);
        repeat (2) tick();

        // 8'hC1 MSB-first; flipping MSB_FIRST mid-word must not matter
        MSB_FIRST = 1'b1;
        send(8'hC1);
        tick();
        got = '0;
        for (int i = 0; i < W; i++) begin
            if (i == 3) MSB_FIRST = 1'b0;
            tick();
            got[i] = S_DATA;
        end
        chk("t3_bits", 32'(got), 32'h0000_0083);
        chk("t3_done", 32'(DONE), 32'd1);
        repeat (2) tick();

        // 8'h0F then 8'hF0 streamed back-to-back
        MSB_FIRST = 1'b0;
        send(8'h0F);
        P_DATA = 8'hF0;
        DATA_VALID = 1'b1;
        tick();
        got16 = '0;
        done_idx.delete();
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == 0) DATA_VALID = 1'b0;
            got16[i] = S_DATA;
            if (DONE) done_idx.push_back(i);
            if (i < 15) chk("t4_busy_no_gap", 32'(BUSY), 32'd1);
        end
        chk("t4_bits", 32'(got16), 32'h0000_F00F);
        chk("t4_done_count", 32'(done_idx.size()), 32'd2);
        if (done_idx.size() == 2) begin
            chk("t4_done0", 32'(done_idx[0]), 32'd7);
            chk("t4_done_spacing", 32'(done_idx[1] - done_idx[0]), 32'd8);
        end
        tick();
        chk("t4_busy_fall", 32'(BUSY), 32'd0);
        repeat (2) tick();

        // 8'h5A with EN every 4th cycle; a second word waits in the hold
        EN = 1'b0;
        send(8'h5A);
        tick();
        got = '0;
        ens = 0;
        illegal = 0;
        done_at = -1;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            EN = (k % 4 == 0);
            if (k == 1) begin
                P_DATA = 8'h33;
                DATA_VALID = 1'b1;
            end
            if (k == 2) P_DATA = 8'hFF;
            if (k == 3) chk("t5_ready_low_hold_full", 32'(DATA_READY), 32'd0);
            if (k == 5) DATA_VALID = 1'b0;
            prev = S_DATA;
            cur_en = EN;
            tick();
            if (cur_en) begin
                if (ens < W) got[ens] = S_DATA;
                ens++;
            end else if (S_DATA !== prev) begin
                illegal++;
            end
            if (DONE) begin
                done_at = ens;
                seen = 1'b1;
            end
        end
        chk("t5_no_change_without_en", 32'(illegal), 32'd0);
        chk("t5_bits", 32'(got), 32'h0000_005A);
        chk("t5_done_after_8th_en", 32'(done_at), 32'd8);
        EN = 1'b1;
        got = '0;
        for (int i = 0; i < W; i++) begin
            tick();
            got[i] = S_DATA;
        end
        chk("t5_held_word_intact", 32'(got), 32'h0000_0033);
        repeat (2) tick();

        // Parity of 8'h07 for even and odd parity
`ifdef UART_TX_SER_PARITY_EN
        exp_par = 1'b1;
`else
        exp_par = 1'b0;
`endif
        PAR_TYPE = 1'b0;
        send(8'h07);
        tick();
        chk("t6_par_even", 32'(PAR_BIT), 32'(exp_par));
        PAR_TYPE = 1'b1;
        tick();
        chk("t6_par_held", 32'(PAR_BIT), 32'(exp_par));
        repeat (10) tick();
        send(8'h07);
        tick();
        chk("t6_par_odd", 32'(PAR_BIT), 32'd0);
        repeat (10) tick();
        PAR_TYPE = 1'b0;

        // Asynchronous reset in the middle of a word
        send(8'hC1);
        repeat (3) tick();
        #1 RST = 1'b0;
        #1;
        chk("t1_rst_s_data", 32'(S_DATA), 32'd0);
        chk("t1_rst_done", 32'(DONE), 32'd0);
        chk("t1_rst_busy", 32'(BUSY), 32'd0);
        chk("t1_rst_ready", 32'(DATA_READY), 32'd1);
        tick();
        RST = 1'b1;
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (DONE) dn++;
        end
        chk("t1_no_done_after_reset", 32'(dn), 32'd0);
        chk("t1_idle_after_reset", 32'(BUSY), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
